i2c_slave_ctrl: RTL

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

---
 rtl/i2c_slave_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller.
// Decodes START/STOP/SCL edges from pre-filtered, clk-synchronous SCL/SDA,
// answers to SLAVE_ADDR, receives write bytes and serves read bytes.
// Ports:
//   clk, rst_n            - system clock, async active-low reset
//   scl_in, sda_in        - synchronised bus inputs
//   tx_data_in            - read byte, loaded when tx_req_out pulses
//   rx_data_out           - last byte written by the master
//   rx_valid_out          - one-cycle pulse on rx_data_out update
//   tx_req_out            - one-cycle pulse when tx_data_in is loaded
//   busy_out              - controller not idle
//   oe_out, osel_out,
//   ack_out, sd_out       - SDA output-mux controls (0 on a path pulls SDA low)
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [7:0] tx_data_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    output logic       tx_req_out,
    output logic       busy_out,
    output logic       oe_out,
    output logic       osel_out,
    output logic       ack_out,
    output logic       sd_out
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                nack_q, nack_d;
    logic                scl_q, scl_d;
    logic                sda_q, sda_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_req_q, tx_req_d;
    logic                busy_q, busy_d;
    logic                oe_q, oe_d;
    logic                osel_q, osel_d;
    logic                ack_q, ack_d;
    logic                sd_q, sd_d;

    logic rise, fall, start_ev, stop_ev;
    logic do_release, do_load, do_ack;

    // Bus event decode against the previous-cycle samples
    assign rise     =  scl_in & ~scl_q;
    assign fall     = ~scl_in &  scl_q;
    assign start_ev =  scl_in &  scl_q &  sda_q & ~sda_in;
    assign stop_ev  =  scl_in &  scl_q & ~sda_q &  sda_in;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            osel_q     <= 1'b0;
            ack_q      <= 1'b1;
            sd_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            osel_q     <= osel_d;
            ack_q      <= ack_d;
            sd_q       <= sd_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        nack_d     = nack_q;
        scl_d      = scl_in;
        sda_d      = sda_in;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        oe_d       = oe_q;
        osel_d     = osel_q;
        ack_d      = ack_q;
        sd_d       = sd_q;
        do_release = 1'b0;
        do_load    = 1'b0;
        do_ack     = 1'b0;

        if (start_ev) begin
            state_d    = ADDR;
            cnt_d      = '0;
            do_release = 1'b1;
        end else if (stop_ev) begin
            state_d    = IDLE;
            do_release = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (rise && cnt_q != CNT_W'(8)) begin
                        shreg_d = {shreg_q[BYTE_W-2:0], sda_in};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (fall && cnt_q == CNT_W'(8)) begin
                        if (shreg_q[7:1] == SLAVE_ADDR) begin
                            state_d = ADDR_ACK;
                            do_ack  = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            do_release = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (fall) begin
                        if (shreg_q[0]) begin
                            do_load = 1'b1;
                        end else begin
                            state_d    = WR_DATA;
                            cnt_d      = '0;
                            do_release = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (rise && cnt_q != CNT_W'(8)) begin
                        shreg_d = {shreg_q[BYTE_W-2:0], sda_in};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (fall && cnt_q == CNT_W'(8)) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                        do_ack     = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (fall) begin
                        state_d    = WR_DATA;
                        cnt_d      = '0;
                        do_release = 1'b1;
                    end
                end
                RD_DATA: begin
                    // cnt counts bits already clocked out; the 8th fall ends the byte
                    if (fall) begin
                        if (cnt_q == CNT_W'(7)) begin
                            state_d    = RD_ACK;
                            do_release = 1'b1;
                        end else begin
                            sd_d    = shreg_q[BYTE_W-2];
                            shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RD_ACK: begin
                    if (rise) begin
                        nack_d = sda_in;
                    end else if (fall) begin
                        if (nack_q) begin
                            state_d    = IDLE;
                            do_release = 1'b1;
                        end else begin
                            do_load = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    do_release = 1'b1;
                end
            endcase
        end

        // Output-mux updates shared by several transitions
        if (do_release) begin
            oe_d   = 1'b0;
            osel_d = 1'b0;
            ack_d  = 1'b1;
            sd_d   = 1'b1;
        end
        if (do_ack) begin
            oe_d   = 1'b1;
            osel_d = 1'b0;
            ack_d  = 1'b0;
            sd_d   = 1'b1;
        end
        if (do_load) begin
            state_d  = RD_DATA;
            tx_req_d = 1'b1;
            shreg_d  = tx_data_in;
            cnt_d    = '0;
            oe_d     = 1'b1;
            osel_d   = 1'b1;
            ack_d    = 1'b1;
            sd_d     = tx_data_in[BYTE_W-1];
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_data_out  = rx_data_q;
    assign rx_valid_out = rx_valid_q;
    assign tx_req_out   = tx_req_q;
    assign busy_out     = busy_q;
    assign oe_out       = oe_q;
    assign osel_out     = osel_q;
    assign ack_out      = ack_q;
    assign sd_out       = sd_q;

endmodule
